// File: rtl/mem_resp_wait.sv
// +----------------------------------------------------------------------------+
// | mem_resp_wait: handshaked data-memory responder with programmable wait      |
// | states and byte-lane stores. Optional: MISALIGN_TRAP_EN (fault misaligned). |
// | Revision: 1.0                                                                |
// +----------------------------------------------------------------------------+
`default_nettype none

module mem_resp_wait #(
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned WAIT_CYC = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [1:0]  req_size_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o
);

  localparam int unsigned DEPTH     = 1 << ADDR_W;
  localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYC);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                we_q, we_d;
  logic [1:0]          size_q, size_d;
  logic [ADDR_W+1:0]   addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [31:0]         rdata_q, rdata_d;
  logic                err_q, err_d;

  logic [31:0]         mem_q [DEPTH];

  logic                commit;
  logic                fault;
  logic                mem_we;
  logic [3:0]          lane_en;
  logic [31:0]         lane_data;
  logic [ADDR_W-1:0]   word_idx;
  logic [31:0]         rd_word;
  logic                unused_addr;

  // Address bits above the array wrap away.
  assign unused_addr = ^req_addr_i[31:ADDR_W+2];

  assign word_idx = addr_q[ADDR_W+1:2];
  assign rd_word  = mem_q[word_idx];

`ifdef MISALIGN_TRAP_EN
  assign fault = ((size_q == 2'b01) && addr_q[0])
              || ((size_q == 2'b10) && (addr_q[1:0] != 2'b00))
              ||  (size_q == 2'b11);
`else
  assign fault = 1'b0;
`endif

  always_comb begin
    lane_en   = 4'b1111;
    lane_data = wdata_q;
    case (size_q)
      2'b00: begin
        lane_en   = 4'b0001 << addr_q[1:0];
        lane_data = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        lane_en   = addr_q[1] ? 4'b1100 : 4'b0011;
        lane_data = {2{wdata_q[15:0]}};
      end
      default: begin
        lane_en   = 4'b1111;
        lane_data = wdata_q;
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    size_d  = size_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    commit  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_valid_i) begin
          we_d    = req_we_i;
          size_d  = req_size_i;
          addr_d  = req_addr_i[ADDR_W+1:0];
          wdata_d = req_wdata_i;
          cnt_d   = WAIT_INIT;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          commit  = 1'b1;
          rdata_d = (we_q || fault) ? 32'd0 : rd_word;
          err_d   = fault;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP: begin
        if (rsp_ready_i) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      size_q  <= 2'b00;
      addr_q  <= '0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      size_q  <= size_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // The array has no reset; a reset during WAIT forces IDLE so no write commits.
  assign mem_we = commit && we_q && !fault && rst_ni;

  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      for (int k = 0; k < 4; k++) begin
        if (lane_en[k]) begin
          mem_q[word_idx][8*k +: 8] <= lane_data[8*k +: 8];
        end
      end
    end
  end

  assign req_ready_o = (state_q == S_IDLE) && rst_ni;
  assign rsp_valid_o = (state_q == S_RESP);
  assign rsp_rdata_o = rdata_q;
  assign rsp_err_o   = err_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_resp_wait.sv
// Scoreboard bench for mem_resp_wait: directed requests push expected responses,
// a monitor pops and compares on every response handshake.
`default_nettype none

module tb_mem_resp_wait;

  logic        clk;
  logic        rst_n;
  logic        req_valid, req_ready, req_we, rsp_valid, rsp_ready, rsp_err;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata, rsp_rdata;

  logic        c0_req_valid, c0_req_ready, c0_req_we, c0_rsp_valid, c0_rsp_err;
  logic [1:0]  c0_req_size;
  logic [31:0] c0_req_addr, c0_req_wdata, c0_rsp_rdata;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;
  exp_t exp_q[$];

`ifdef MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  mem_resp_wait #(.ADDR_W(8), .WAIT_CYC(2)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_we_i(req_we), .req_size_i(req_size),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err)
  );

  mem_resp_wait #(.ADDR_W(8), .WAIT_CYC(0)) dut0 (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(c0_req_valid), .req_ready_o(c0_req_ready),
    .req_we_i(c0_req_we), .req_size_i(c0_req_size),
    .req_addr_i(c0_req_addr), .req_wdata_i(c0_req_wdata),
    .rsp_valid_o(c0_rsp_valid), .rsp_ready_i(1'b1),
    .rsp_rdata_o(c0_rsp_rdata), .rsp_err_o(c0_rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%08h required=%08h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rsp actual=%08h required=none", rsp_rdata);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("rsp_rdata", rsp_rdata, e.rdata);
        chk("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
      end
    end
  end

  // Caller is aligned 1 time unit after a rising edge; returns likewise after accept.
  task automatic issue(input logic we, input logic [1:0] sz, input logic [31:0] a,
                       input logic [31:0] d);
    int n = 0;
    while (!req_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (!req_ready) chk("req_ready_timeout", {31'd0, req_ready}, 32'd1);
    req_we = we; req_size = sz; req_addr = a; req_wdata = d; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp();
    int n = 0;
    while (!rsp_valid && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (!rsp_valid) chk("rsp_valid_timeout", {31'd0, rsp_valid}, 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic txn(input logic we, input logic [1:0] sz, input logic [31:0] a,
                     input logic [31:0] d, input logic [31:0] er, input logic ee);
    exp_t e;
    e.rdata = er; e.err = ee;
    exp_q.push_back(e);
    issue(we, sz, a, d);
    wait_rsp();
  endtask

  initial begin
    exp_t e;
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b10;
    req_addr = 32'd0; req_wdata = 32'd0; rsp_ready = 1'b1;
    c0_req_valid = 1'b0; c0_req_we = 1'b0; c0_req_size = 2'b10;
    c0_req_addr = 32'd0; c0_req_wdata = 32'd0;

    #12;
    chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
    @(posedge clk); #3; rst_n = 1'b1;
    #1;
    chk("rel_req_ready", {31'd0, req_ready}, 32'd1);
    @(posedge clk); #1;

    // Word store with latency probe (WAIT_CYC=2)
    e.rdata = 32'd0; e.err = 1'b0; exp_q.push_back(e);
    issue(1'b1, 2'b10, 32'h10, 32'hDEADBEEF);
    for (int i = 1; i <= 3; i++) begin
      chk("lat2_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      chk("lat2_req_ready", {31'd0, req_ready}, 32'd0);
      @(posedge clk); #1;
    end
    chk("lat2_rsp_valid_hi", {31'd0, rsp_valid}, 32'd1);
    @(posedge clk); #1;

    txn(1'b0, 2'b10, 32'h10,  32'd0, 32'hDEADBEEF, 1'b0);
    txn(1'b0, 2'b10, 32'h410, 32'd0, 32'hDEADBEEF, 1'b0);

    txn(1'b1, 2'b10, 32'h20, 32'h11223344, 32'd0, 1'b0);
    txn(1'b1, 2'b00, 32'h22, 32'h000000AA, 32'd0, 1'b0);
    txn(1'b0, 2'b10, 32'h20, 32'd0, 32'h11AA3344, 1'b0);
    txn(1'b1, 2'b01, 32'h20, 32'h0000BEEF, 32'd0, 1'b0);
    txn(1'b0, 2'b10, 32'h20, 32'd0, 32'h11AABEEF, 1'b0);

    // Backpressure with a second request held pending
    rsp_ready = 1'b0;
    e.rdata = 32'h11AABEEF; e.err = 1'b0; exp_q.push_back(e);
    issue(1'b0, 2'b10, 32'h20, 32'd0);
    req_we = 1'b1; req_addr = 32'h40; req_wdata = 32'h55555555; req_valid = 1'b1;
    wait_rsp();
    for (int i = 0; i < 5; i++) begin
      chk("bp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      chk("bp_rsp_rdata", rsp_rdata, 32'h11AABEEF);
      chk("bp_req_ready", {31'd0, req_ready}, 32'd0);
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1; req_valid = 1'b0;
    @(posedge clk); #1;
    chk("bp_req_ready_after", {31'd0, req_ready}, 32'd1);
    chk("bp_rsp_valid_after", {31'd0, rsp_valid}, 32'd0);

    // Reset in WAIT discards the pending store
    issue(1'b1, 2'b10, 32'h20, 32'h12345678);
    rst_n = 1'b0;
    #1;
    chk("rw_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rw_req_ready", {31'd0, req_ready}, 32'd0);
    chk("rw_rsp_rdata", rsp_rdata, 32'd0);
    chk("rw_rsp_err", {31'd0, rsp_err}, 32'd0);
    @(posedge clk); #3; rst_n = 1'b1;
    @(posedge clk); #1;
    txn(1'b0, 2'b10, 32'h20, 32'd0, 32'h11AABEEF, 1'b0);

    // Half store with addr[0]=1
    txn(1'b1, 2'b01, 32'h23, 32'h00005566, 32'd0, TRAP);
    txn(1'b0, 2'b10, 32'h20, 32'd0, TRAP ? 32'h11AABEEF : 32'h5566BEEF, 1'b0);

    // Misaligned word store
    txn(1'b1, 2'b10, 32'h30, 32'h01020304, 32'd0, 1'b0);
    txn(1'b1, 2'b10, 32'h31, 32'hCAFEBABE, 32'd0, TRAP);
    txn(1'b0, 2'b10, 32'h30, 32'd0, TRAP ? 32'h01020304 : 32'hCAFEBABE, 1'b0);

    // Latency with WAIT_CYC=0
    c0_req_we = 1'b1; c0_req_size = 2'b10; c0_req_addr = 32'h0;
    c0_req_wdata = 32'hA5A5A5A5; c0_req_valid = 1'b1;
    chk("lat0_req_ready", {31'd0, c0_req_ready}, 32'd1);
    @(posedge clk); #1;
    c0_req_valid = 1'b0;
    chk("lat0_rsp_valid_lo", {31'd0, c0_rsp_valid}, 32'd0);
    chk("lat0_req_ready_lo", {31'd0, c0_req_ready}, 32'd0);
    @(posedge clk); #1;
    chk("lat0_rsp_valid_hi", {31'd0, c0_rsp_valid}, 32'd1);
    chk("lat0_rsp_rdata", c0_rsp_rdata, 32'd0);
    @(posedge clk); #1;
    chk("lat0_req_ready_back", {31'd0, c0_req_ready}, 32'd1);

    repeat (3) @(posedge clk);
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL missing_rsp actual=%0d required=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end

endmodule

`default_nettype wire
